// File: rtl/phase_scheduler.sv
// Intersection phase scheduler: NS/EW green-yellow-all-red sequencing with
// latched pedestrian walk service and emergency preemption with minimum green.
module phase_scheduler #(
  parameter int CNT_W     = 8,
  parameter int GREEN_T   = 20,
  parameter int YELLOW_T  = 4,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 10,
  parameter int MIN_GREEN = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ped_req_ns,
  input  logic       ped_req_ew,
  input  logic       emerg_req,
  input  logic       emerg_dir,
  output logic [1:0] ns_light_cmd,
  output logic [1:0] ew_light_cmd,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic       emerg_active,
  output logic [2:0] phase_id,
  output logic       phase_start
);

  typedef enum logic [2:0] {
    NSG = 3'd0,
    NSY = 3'd1,
    AR1 = 3'd2,
    EWG = 3'd3,
    EWY = 3'd4,
    AR2 = 3'd5,
    EMG = 3'd6
  } state_t;

  localparam logic [1:0] L_GREEN  = 2'b10;
  localparam logic [1:0] L_YELLOW = 2'b01;
  localparam logic [1:0] L_RED    = 2'b00;

  localparam logic [CNT_W-1:0] GREEN_END  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_END = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_END = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_END   = CNT_W'(WALK_T - 1);
  localparam logic [CNT_W-1:0] MIN_END    = CNT_W'(MIN_GREEN - 1);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic             pend_ns;
  logic             pend_ew;
  logic             dir_q;
  logic             nxt_dir;
  logic [1:0]       ns_nxt;
  logic [1:0]       ew_nxt;
  logic             enter_nsg;
  logic             enter_ewg;

  // Terminal count always wins over emergency; emergency is re-evaluated
  // in whichever state the terminal transition lands in.
  always_comb begin
    nxt     = state;
    nxt_dir = dir_q;
    case (state)
      NSG: begin
        if (cnt == GREEN_END || (emerg_req && emerg_dir && cnt >= MIN_END)) begin
          nxt = NSY;
        end else if (emerg_req && !emerg_dir) begin
          nxt     = EMG;
          nxt_dir = 1'b0;
        end
      end
      NSY: if (cnt == YELLOW_END) nxt = AR1;
      AR1: begin
        if (cnt == ALLRED_END) begin
          if (emerg_req) begin
            nxt     = EMG;
            nxt_dir = emerg_dir;
          end else begin
            nxt = EWG;
          end
        end
      end
      EWG: begin
        if (cnt == GREEN_END || (emerg_req && !emerg_dir && cnt >= MIN_END)) begin
          nxt = EWY;
        end else if (emerg_req && emerg_dir) begin
          nxt     = EMG;
          nxt_dir = 1'b1;
        end
      end
      EWY: if (cnt == YELLOW_END) nxt = AR2;
      AR2: begin
        if (cnt == ALLRED_END) begin
          if (emerg_req) begin
            nxt     = EMG;
            nxt_dir = emerg_dir;
          end else begin
            nxt = NSG;
          end
        end
      end
      EMG: if (!emerg_req) nxt = dir_q ? EWY : NSY;
      default: nxt = NSG;
    endcase
  end

  always_comb begin
    ns_nxt = L_RED;
    ew_nxt = L_RED;
    case (nxt)
      NSG: ns_nxt = L_GREEN;
      NSY: ns_nxt = L_YELLOW;
      EWG: ew_nxt = L_GREEN;
      EWY: ew_nxt = L_YELLOW;
      EMG: begin
        if (nxt_dir) ew_nxt = L_GREEN;
        else         ns_nxt = L_GREEN;
      end
      default: begin
        ns_nxt = L_RED;
        ew_nxt = L_RED;
      end
    endcase
  end

  assign enter_nsg = (nxt == NSG) && (state != NSG);
  assign enter_ewg = (nxt == EWG) && (state != EWG);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= NSG;
      cnt          <= '0;
      pend_ns      <= 1'b0;
      pend_ew      <= 1'b0;
      dir_q        <= 1'b0;
      phase_start  <= 1'b0;
      ns_light_cmd <= L_GREEN;
      ew_light_cmd <= L_RED;
      walk_ns      <= 1'b0;
      walk_ew      <= 1'b0;
      emerg_active <= 1'b0;
      phase_id     <= 3'd0;
    end else begin
      state        <= nxt;
      dir_q        <= nxt_dir;
      cnt          <= (nxt != state) ? '0 : cnt + 1'b1;
      phase_start  <= (nxt != state);
      ns_light_cmd <= ns_nxt;
      ew_light_cmd <= ew_nxt;
      emerg_active <= (nxt == EMG);
      phase_id     <= nxt;

      // A request in the cycle that decides green entry is consumed with the flag.
      pend_ns <= enter_nsg ? 1'b0 : (pend_ns | ped_req_ns);
      pend_ew <= enter_ewg ? 1'b0 : (pend_ew | ped_req_ew);

      if (enter_nsg)       walk_ns <= pend_ns | ped_req_ns;
      else if (nxt == NSG) walk_ns <= walk_ns && (cnt < WALK_END);
      else                 walk_ns <= 1'b0;

      if (enter_ewg)       walk_ew <= pend_ew | ped_req_ew;
      else if (nxt == EWG) walk_ew <= walk_ew && (cnt < WALK_END);
      else                 walk_ew <= 1'b0;
    end
  end

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed bench for phase_scheduler: normal cycle, pedestrian walk,
// emergency preemption in both directions and reset during EMG.
module tb_phase_scheduler;

  logic       clk;
  logic       reset;
  logic       ped_req_ns;
  logic       ped_req_ew;
  logic       emerg_req;
  logic       emerg_dir;
  logic [1:0] ns_light_cmd;
  logic [1:0] ew_light_cmd;
  logic       walk_ns;
  logic       walk_ew;
  logic       emerg_active;
  logic [2:0] phase_id;
  logic       phase_start;

  int n_checks = 0;
  int n_fail   = 0;

  phase_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .ped_req_ns   (ped_req_ns),
    .ped_req_ew   (ped_req_ew),
    .emerg_req    (emerg_req),
    .emerg_dir    (emerg_dir),
    .ns_light_cmd (ns_light_cmd),
    .ew_light_cmd (ew_light_cmd),
    .walk_ns      (walk_ns),
    .walk_ew      (walk_ew),
    .emerg_active (emerg_active),
    .phase_id     (phase_id),
    .phase_start  (phase_start)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got=running exp=finished");
    $fatal(1, "watchdog");
  end

  // Normal 52-cycle schedule with default parameters, cycle 0 = reset release.
  function automatic logic [2:0] exp_normal_phase(input int k);
    int m;
    m = k % 52;
    if (m < 20)      return 3'd0;
    else if (m < 24) return 3'd1;
    else if (m < 26) return 3'd2;
    else if (m < 46) return 3'd3;
    else if (m < 50) return 3'd4;
    else             return 3'd5;
  endfunction

  function automatic logic exp_normal_start(input int k);
    return (k == 20 || k == 24 || k == 26 || k == 46 || k == 50 || k == 52);
  endfunction

  function automatic logic [1:0] exp_ns(input logic [2:0] p, input logic dir);
    if (p == 3'd0 || (p == 3'd6 && !dir)) return 2'b10;
    if (p == 3'd1) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [1:0] exp_ew(input logic [2:0] p, input logic dir);
    if (p == 3'd3 || (p == 3'd6 && dir)) return 2'b10;
    if (p == 3'd4) return 2'b01;
    return 2'b00;
  endfunction

  // driver: leaves the bench at the negedge of cycle 0 after release
  task automatic do_reset();
    reset      = 1'b0;
    ped_req_ns = 1'b0;
    ped_req_ew = 1'b0;
    emerg_req  = 1'b0;
    emerg_dir  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    ped_req_ns = 1'b1;
    ped_req_ew = 1'b1;
    emerg_req  = 1'b1;
    emerg_dir  = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (phase_id !== 3'd0) begin n_fail++; $display("FAIL reset_phase_id got=%0d exp=0", phase_id); end
    n_checks++; if (ns_light_cmd !== 2'b10) begin n_fail++; $display("FAIL reset_ns got=%b exp=10", ns_light_cmd); end
    n_checks++; if (ew_light_cmd !== 2'b00) begin n_fail++; $display("FAIL reset_ew got=%b exp=00", ew_light_cmd); end
    n_checks++; if ({walk_ns, walk_ew} !== 2'b00) begin n_fail++; $display("FAIL reset_walk got=%b exp=00", {walk_ns, walk_ew}); end
    n_checks++; if (emerg_active !== 1'b0) begin n_fail++; $display("FAIL reset_emerg got=%b exp=0", emerg_active); end
    n_checks++; if (phase_start !== 1'b0) begin n_fail++; $display("FAIL reset_phase_start got=%b exp=0", phase_start); end
  endtask

  task automatic test_normal_cycle();
    logic [2:0] p;
    do_reset();
    for (int k = 0; k <= 52; k++) begin
      p = exp_normal_phase(k);
      n_checks++; if (phase_id !== p) begin n_fail++; $display("FAIL normal_phase k=%0d got=%0d exp=%0d", k, phase_id, p); end
      n_checks++; if (phase_start !== exp_normal_start(k)) begin n_fail++; $display("FAIL normal_start k=%0d got=%b exp=%b", k, phase_start, exp_normal_start(k)); end
      n_checks++; if (ns_light_cmd !== exp_ns(p, 1'b0)) begin n_fail++; $display("FAIL normal_ns k=%0d got=%b exp=%b", k, ns_light_cmd, exp_ns(p, 1'b0)); end
      n_checks++; if (ew_light_cmd !== exp_ew(p, 1'b0)) begin n_fail++; $display("FAIL normal_ew k=%0d got=%b exp=%b", k, ew_light_cmd, exp_ew(p, 1'b0)); end
      n_checks++; if ({walk_ns, walk_ew, emerg_active} !== 3'b000) begin n_fail++; $display("FAIL normal_idle k=%0d got=%b exp=000", k, {walk_ns, walk_ew, emerg_active}); end
      @(negedge clk);
    end
  endtask

  task automatic test_ped_walk();
    logic exp_w;
    do_reset();
    for (int k = 0; k <= 97; k++) begin
      if (k == 5) ped_req_ew = 1'b1;
      if (k == 6) ped_req_ew = 1'b0;
      exp_w = (k >= 26 && k <= 35);
      n_checks++; if (walk_ew !== exp_w) begin n_fail++; $display("FAIL ped_walk_ew k=%0d got=%b exp=%b", k, walk_ew, exp_w); end
      n_checks++; if (walk_ns !== 1'b0) begin n_fail++; $display("FAIL ped_walk_ns k=%0d got=%b exp=0", k, walk_ns); end
      n_checks++; if (phase_id !== exp_normal_phase(k)) begin n_fail++; $display("FAIL ped_phase k=%0d got=%0d exp=%0d", k, phase_id, exp_normal_phase(k)); end
      @(negedge clk);
    end
  endtask

  task automatic test_emerg_preempt_ew();
    logic [2:0] p;
    logic       s;
    do_reset();
    for (int k = 0; k <= 31; k++) begin
      if (k == 2) begin emerg_req = 1'b1; emerg_dir = 1'b1; end
      if (k == 12) ped_req_ns = 1'b1;
      if (k == 13) begin ped_req_ns = 1'b0; emerg_dir = 1'b0; end
      if (k == 15) emerg_req = 1'b0;
      if (k < 5)       p = 3'd0;
      else if (k < 9)  p = 3'd1;
      else if (k < 11) p = 3'd2;
      else if (k < 16) p = 3'd6;
      else if (k < 20) p = 3'd4;
      else if (k < 22) p = 3'd5;
      else             p = 3'd0;
      s = (k == 5 || k == 9 || k == 11 || k == 16 || k == 20 || k == 22);
      n_checks++; if (phase_id !== p) begin n_fail++; $display("FAIL emg_ew_phase k=%0d got=%0d exp=%0d", k, phase_id, p); end
      n_checks++; if (phase_start !== s) begin n_fail++; $display("FAIL emg_ew_start k=%0d got=%b exp=%b", k, phase_start, s); end
      n_checks++; if (ns_light_cmd !== exp_ns(p, 1'b1)) begin n_fail++; $display("FAIL emg_ew_ns k=%0d got=%b exp=%b", k, ns_light_cmd, exp_ns(p, 1'b1)); end
      n_checks++; if (ew_light_cmd !== exp_ew(p, 1'b1)) begin n_fail++; $display("FAIL emg_ew_ew k=%0d got=%b exp=%b", k, ew_light_cmd, exp_ew(p, 1'b1)); end
      n_checks++; if (emerg_active !== (p == 3'd6)) begin n_fail++; $display("FAIL emg_ew_active k=%0d got=%b exp=%b", k, emerg_active, (p == 3'd6)); end
      n_checks++; if (walk_ns !== (k >= 22)) begin n_fail++; $display("FAIL emg_ew_walk_ns k=%0d got=%b exp=%b", k, walk_ns, (k >= 22)); end
      n_checks++; if (walk_ew !== 1'b0) begin n_fail++; $display("FAIL emg_ew_walk_ew k=%0d got=%b exp=0", k, walk_ew); end
      @(negedge clk);
    end
  endtask

  task automatic test_emerg_same_dir();
    logic [2:0] p;
    logic       s;
    do_reset();
    for (int k = 0; k <= 60; k++) begin
      if (k == 5) ped_req_ns = 1'b1;
      if (k == 6) ped_req_ns = 1'b0;
      if (k == 54) begin emerg_req = 1'b1; emerg_dir = 1'b0; end
      if (k == 57) emerg_req = 1'b0;
      if (k < 55)      p = exp_normal_phase(k);
      else if (k < 58) p = 3'd6;
      else             p = 3'd1;
      s = exp_normal_start(k) || k == 55 || k == 58;
      n_checks++; if (phase_id !== p) begin n_fail++; $display("FAIL emg_ns_phase k=%0d got=%0d exp=%0d", k, phase_id, p); end
      n_checks++; if (phase_start !== s) begin n_fail++; $display("FAIL emg_ns_start k=%0d got=%b exp=%b", k, phase_start, s); end
      n_checks++; if (ns_light_cmd !== exp_ns(p, 1'b0)) begin n_fail++; $display("FAIL emg_ns_ns k=%0d got=%b exp=%b", k, ns_light_cmd, exp_ns(p, 1'b0)); end
      n_checks++; if (ew_light_cmd !== exp_ew(p, 1'b0)) begin n_fail++; $display("FAIL emg_ns_ew k=%0d got=%b exp=%b", k, ew_light_cmd, exp_ew(p, 1'b0)); end
      n_checks++; if (walk_ns !== (k >= 52 && k <= 54)) begin n_fail++; $display("FAIL emg_ns_walk k=%0d got=%b exp=%b", k, walk_ns, (k >= 52 && k <= 54)); end
      n_checks++; if (emerg_active !== (p == 3'd6)) begin n_fail++; $display("FAIL emg_ns_active k=%0d got=%b exp=%b", k, emerg_active, (p == 3'd6)); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_in_emg();
    do_reset();
    emerg_req = 1'b1;
    emerg_dir = 1'b0;
    @(negedge clk);
    n_checks++; if (phase_id !== 3'd6) begin n_fail++; $display("FAIL rst_emg_enter got=%0d exp=6", phase_id); end
    ped_req_ew = 1'b1;
    @(negedge clk);
    ped_req_ew = 1'b0;
    @(negedge clk);
    n_checks++; if (emerg_active !== 1'b1) begin n_fail++; $display("FAIL rst_emg_held got=%b exp=1", emerg_active); end
    reset = 1'b0;
    #1;
    n_checks++; if (phase_id !== 3'd0) begin n_fail++; $display("FAIL rst_emg_phase got=%0d exp=0", phase_id); end
    n_checks++; if (ns_light_cmd !== 2'b10) begin n_fail++; $display("FAIL rst_emg_ns got=%b exp=10", ns_light_cmd); end
    n_checks++; if (ew_light_cmd !== 2'b00) begin n_fail++; $display("FAIL rst_emg_ew got=%b exp=00", ew_light_cmd); end
    n_checks++; if (emerg_active !== 1'b0) begin n_fail++; $display("FAIL rst_emg_active got=%b exp=0", emerg_active); end
    emerg_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k <= 52; k++) begin
      n_checks++; if (phase_id !== exp_normal_phase(k)) begin n_fail++; $display("FAIL rst_emg_period k=%0d got=%0d exp=%0d", k, phase_id, exp_normal_phase(k)); end
      n_checks++; if (phase_start !== exp_normal_start(k)) begin n_fail++; $display("FAIL rst_emg_start k=%0d got=%b exp=%b", k, phase_start, exp_normal_start(k)); end
      n_checks++; if (walk_ew !== 1'b0) begin n_fail++; $display("FAIL rst_emg_discard k=%0d got=%b exp=0", k, walk_ew); end
      @(negedge clk);
    end
  endtask

  initial begin
    reset      = 1'b0;
    ped_req_ns = 1'b0;
    ped_req_ew = 1'b0;
    emerg_req  = 1'b0;
    emerg_dir  = 1'b0;
    test_reset();
    test_normal_cycle();
    test_ped_walk();
    test_emerg_preempt_ew();
    test_emerg_same_dir();
    test_reset_in_emg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
